// File: rtl/br_meta_pipe.sv
// Carries branch-prediction metadata from fetch to EX/MEM alongside the pipeline,
// flags mispredicted branches, squashes younger work and keeps saturating branch counters.
module br_meta_pipe #(
    parameter logic [6:0]  BR_OPCODE = 7'b1100011,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic             lc_br_dir,
    input  logic             gl_br_dir,
    input  logic             tn_br_dir,
    input  logic [6:0]       ex_opcode,
    input  logic             ex_br_en,
    output logic             ex_mem_lc_dir,
    output logic             ex_mem_gl_dir,
    output logic             ex_mem_br_en,
    output logic [6:0]       ex_mem_opcode,
    output logic [31:0]      ex_mem_pc,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic             vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic [31:0]      pc_p0_q, pc_p0_d, pc_p1_q, pc_p1_d, pc_p2_q, pc_p2_d;
    logic             lc_p0_q, lc_p0_d, lc_p1_q, lc_p1_d, lc_p2_q, lc_p2_d;
    logic             gl_p0_q, gl_p0_d, gl_p1_q, gl_p1_d, gl_p2_q, gl_p2_d;
    logic             tn_p0_q, tn_p0_d, tn_p1_q, tn_p1_d, tn_p2_q, tn_p2_d;
    logic [6:0]       opc_p2_q, opc_p2_d;
    logic             br_en_p2_q, br_en_p2_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;
    logic             is_br_p2;

    assign is_br_p2   = vld_p2_q && (opc_p2_q == BR_OPCODE);
    assign mispredict = is_br_p2 && (tn_p2_q != br_en_p2_q);

    always_comb begin
        vld_p0_d   = vld_p0_q;
        pc_p0_d    = pc_p0_q;
        lc_p0_d    = lc_p0_q;
        gl_p0_d    = gl_p0_q;
        tn_p0_d    = tn_p0_q;
        vld_p1_d   = vld_p1_q;
        pc_p1_d    = pc_p1_q;
        lc_p1_d    = lc_p1_q;
        gl_p1_d    = gl_p1_q;
        tn_p1_d    = tn_p1_q;
        vld_p2_d   = vld_p2_q;
        pc_p2_d    = pc_p2_q;
        lc_p2_d    = lc_p2_q;
        gl_p2_d    = gl_p2_q;
        tn_p2_d    = tn_p2_q;
        opc_p2_d   = opc_p2_q;
        br_en_p2_d = br_en_p2_q;
        br_cnt_d   = br_cnt_q;
        mp_cnt_d   = mp_cnt_q;

        if (!stall) begin
            // IF/ID: capture fetch slot; a mispredict kills it
            vld_p0_d = if_valid & ~mispredict;
            pc_p0_d  = if_pc;
            lc_p0_d  = lc_br_dir;
            gl_p0_d  = gl_br_dir;
            tn_p0_d  = tn_br_dir;

            // ID/EX: on a squash take fetch inputs as an invalid entry
            if (mispredict) begin
                vld_p1_d = 1'b0;
                pc_p1_d  = if_pc;
                lc_p1_d  = lc_br_dir;
                gl_p1_d  = gl_br_dir;
                tn_p1_d  = tn_br_dir;
            end else begin
                vld_p1_d = vld_p0_q;
                pc_p1_d  = pc_p0_q;
                lc_p1_d  = lc_p0_q;
                gl_p1_d  = gl_p0_q;
                tn_p1_d  = tn_p0_q;
            end

            // EX/MEM: join metadata with the resolved outcome from EX
            vld_p2_d   = vld_p1_q & ~mispredict;
            pc_p2_d    = pc_p1_q;
            lc_p2_d    = lc_p1_q;
            gl_p2_d    = gl_p1_q;
            tn_p2_d    = tn_p1_q;
            opc_p2_d   = ex_opcode;
            br_en_p2_d = ex_br_en;

            if (is_br_p2)   br_cnt_d = sat_inc(br_cnt_q);
            if (mispredict) mp_cnt_d = sat_inc(mp_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0_q   <= 1'b0;
            pc_p0_q    <= '0;
            lc_p0_q    <= 1'b0;
            gl_p0_q    <= 1'b0;
            tn_p0_q    <= 1'b0;
            vld_p1_q   <= 1'b0;
            pc_p1_q    <= '0;
            lc_p1_q    <= 1'b0;
            gl_p1_q    <= 1'b0;
            tn_p1_q    <= 1'b0;
            vld_p2_q   <= 1'b0;
            pc_p2_q    <= '0;
            lc_p2_q    <= 1'b0;
            gl_p2_q    <= 1'b0;
            tn_p2_q    <= 1'b0;
            opc_p2_q   <= '0;
            br_en_p2_q <= 1'b0;
            br_cnt_q   <= '0;
            mp_cnt_q   <= '0;
        end else begin
            vld_p0_q   <= vld_p0_d;
            pc_p0_q    <= pc_p0_d;
            lc_p0_q    <= lc_p0_d;
            gl_p0_q    <= gl_p0_d;
            tn_p0_q    <= tn_p0_d;
            vld_p1_q   <= vld_p1_d;
            pc_p1_q    <= pc_p1_d;
            lc_p1_q    <= lc_p1_d;
            gl_p1_q    <= gl_p1_d;
            tn_p1_q    <= tn_p1_d;
            vld_p2_q   <= vld_p2_d;
            pc_p2_q    <= pc_p2_d;
            lc_p2_q    <= lc_p2_d;
            gl_p2_q    <= gl_p2_d;
            tn_p2_q    <= tn_p2_d;
            opc_p2_q   <= opc_p2_d;
            br_en_p2_q <= br_en_p2_d;
            br_cnt_q   <= br_cnt_d;
            mp_cnt_q   <= mp_cnt_d;
        end
    end

    // Bubbles present a zero opcode so downstream predictors skip the update
    assign ex_mem_opcode = vld_p2_q ? opc_p2_q : 7'b0;
    assign ex_mem_lc_dir = lc_p2_q;
    assign ex_mem_gl_dir = gl_p2_q;
    assign ex_mem_br_en  = br_en_p2_q;
    assign ex_mem_pc     = pc_p2_q;
    assign br_count      = br_cnt_q;
    assign mispred_count = mp_cnt_q;

endmodule

// File: tb/tb_br_meta_pipe.sv
// Bench for br_meta_pipe: hand-computed vector table, directed squash/stall/reset/saturation
// sequences and a random run, all scored against a behavioural model through a queue.
module tb_br_meta_pipe;

    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] ALU = 7'b0110011;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        if_valid;
        logic [31:0] if_pc;
        logic        lc, gl, tn;
        logic [6:0]  ex_opcode;
        logic        ex_br_en;
    } in_t;

    typedef struct {
        logic        lc, gl, br;
        logic [6:0]  opc;
        logic [31:0] pc;
        logic        mp;
        logic [3:0]  brc, mpc;
        logic [31:0] brc32, mpc32;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        lc, gl, tn;
    } st_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, if_valid, lc_br_dir, gl_br_dir, tn_br_dir, ex_br_en;
    logic [31:0] if_pc;
    logic [6:0]  ex_opcode;

    logic        a_lc, a_gl, a_br, a_mp;
    logic [6:0]  a_opc;
    logic [31:0] a_pc;
    logic [3:0]  a_brc, a_mpc;
    logic        b_lc, b_gl, b_br, b_mp;
    logic [6:0]  b_opc;
    logic [31:0] b_pc;
    logic [31:0] b_brc, b_mpc;

    br_meta_pipe #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
        .lc_br_dir(lc_br_dir), .gl_br_dir(gl_br_dir), .tn_br_dir(tn_br_dir),
        .ex_opcode(ex_opcode), .ex_br_en(ex_br_en),
        .ex_mem_lc_dir(a_lc), .ex_mem_gl_dir(a_gl), .ex_mem_br_en(a_br),
        .ex_mem_opcode(a_opc), .ex_mem_pc(a_pc), .mispredict(a_mp),
        .br_count(a_brc), .mispred_count(a_mpc)
    );

    br_meta_pipe dut32 (
        .clk(clk), .rst(rst), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
        .lc_br_dir(lc_br_dir), .gl_br_dir(gl_br_dir), .tn_br_dir(tn_br_dir),
        .ex_opcode(ex_opcode), .ex_br_en(ex_br_en),
        .ex_mem_lc_dir(b_lc), .ex_mem_gl_dir(b_gl), .ex_mem_br_en(b_br),
        .ex_mem_opcode(b_opc), .ex_mem_pc(b_pc), .mispredict(b_mp),
        .br_count(b_brc), .mispred_count(b_mpc)
    );

    int checks = 0;
    int errors = 0;
    out_t sb[$];

    st_t         m_s0, m_s1, m_s2;
    logic [6:0]  m_opc;
    logic        m_br;
    logic [3:0]  m_brc, m_mpc;
    logic [31:0] m_brc32, m_mpc32;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic in_t mk(input logic [31:0] rs, st, iv, pc, lc, gl, tn, opc, br);
        in_t r;
        r.rst = rs[0]; r.stall = st[0]; r.if_valid = iv[0]; r.if_pc = pc;
        r.lc = lc[0]; r.gl = gl[0]; r.tn = tn[0];
        r.ex_opcode = opc[6:0]; r.ex_br_en = br[0];
        return r;
    endfunction

    function automatic out_t mko(input logic [31:0] lc, gl, br, opc, pc, mp, brc, mpc);
        out_t o;
        o.lc = lc[0]; o.gl = gl[0]; o.br = br[0]; o.opc = opc[6:0]; o.pc = pc;
        o.mp = mp[0]; o.brc = brc[3:0]; o.mpc = mpc[3:0]; o.brc32 = brc; o.mpc32 = mpc;
        return o;
    endfunction

    function automatic out_t model_out();
        out_t e;
        e.lc    = m_s2.lc;
        e.gl    = m_s2.gl;
        e.br    = m_br;
        e.opc   = m_s2.v ? m_opc : 7'b0;
        e.pc    = m_s2.pc;
        e.mp    = m_s2.v && (m_opc == BR) && (m_s2.tn != m_br);
        e.brc   = m_brc;
        e.mpc   = m_mpc;
        e.brc32 = m_brc32;
        e.mpc32 = m_mpc32;
        return e;
    endfunction

    task automatic model_step(input in_t v);
        st_t  fetch;
        logic mp;
        if (v.rst) begin
            m_s0 = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
            m_s1 = m_s0;
            m_s2 = m_s0;
            m_opc = 7'b0; m_br = 1'b0;
            m_brc = 4'h0; m_mpc = 4'h0; m_brc32 = 32'h0; m_mpc32 = 32'h0;
        end else if (!v.stall) begin
            mp = m_s2.v && (m_opc == BR) && (m_s2.tn != m_br);
            if (m_s2.v && (m_opc == BR)) begin
                if (m_brc != 4'hF) m_brc = m_brc + 4'd1;
                if (m_brc32 != 32'hFFFF_FFFF) m_brc32 = m_brc32 + 32'd1;
                if (mp) begin
                    if (m_mpc != 4'hF) m_mpc = m_mpc + 4'd1;
                    if (m_mpc32 != 32'hFFFF_FFFF) m_mpc32 = m_mpc32 + 32'd1;
                end
            end
            fetch = '{v.if_valid, v.if_pc, v.lc, v.gl, v.tn};
            m_s2 = m_s1;
            if (mp) m_s2.v = 1'b0;
            m_opc = v.ex_opcode;
            m_br  = v.ex_br_en;
            if (mp) begin
                m_s1 = fetch;
                m_s1.v = 1'b0;
            end else begin
                m_s1 = m_s0;
            end
            m_s0 = fetch;
            if (mp) m_s0.v = 1'b0;
        end
    endtask

    task automatic compare_out(input string tag, input out_t e);
        chk({tag, ".lc"},    {31'b0, a_lc}, {31'b0, e.lc});
        chk({tag, ".gl"},    {31'b0, a_gl}, {31'b0, e.gl});
        chk({tag, ".br_en"}, {31'b0, a_br}, {31'b0, e.br});
        chk({tag, ".opc"},   {25'b0, a_opc}, {25'b0, e.opc});
        chk({tag, ".pc"},    a_pc, e.pc);
        chk({tag, ".mp"},    {31'b0, a_mp}, {31'b0, e.mp});
        chk({tag, ".brc4"},  {28'b0, a_brc}, {28'b0, e.brc});
        chk({tag, ".mpc4"},  {28'b0, a_mpc}, {28'b0, e.mpc});
        chk({tag, ".brc32"}, b_brc, e.brc32);
        chk({tag, ".mpc32"}, b_mpc, e.mpc32);
    endtask

    task automatic apply(input in_t v);
        out_t e;
        rst = v.rst; stall = v.stall; if_valid = v.if_valid; if_pc = v.if_pc;
        lc_br_dir = v.lc; gl_br_dir = v.gl; tn_br_dir = v.tn;
        ex_opcode = v.ex_opcode; ex_br_en = v.ex_br_en;
        model_step(v);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare_out("sb", e);
    endtask

    vec_t tbl[9];

    initial begin
        in_t r;
        m_s0 = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
        m_s1 = m_s0; m_s2 = m_s0;
        m_opc = 7'b0; m_br = 1'b0;
        m_brc = 4'h0; m_mpc = 4'h0; m_brc32 = 32'h0; m_mpc32 = 32'h0;

        // reset, 3-edge latency of a correctly predicted branch, then a non-branch pass-through
        tbl[0] = '{i: mk(1, 0, 0, 0,     0, 0, 0, 0,   0), o: mko(0, 0, 0, 0,   0,     0, 0, 0)};
        tbl[1] = '{i: mk(0, 0, 1, 'h40,  1, 0, 1, 0,   0), o: mko(0, 0, 0, 0,   0,     0, 0, 0)};
        tbl[2] = '{i: mk(0, 0, 0, 0,     0, 0, 0, BR,  1), o: mko(0, 0, 1, 0,   0,     0, 0, 0)};
        tbl[3] = '{i: mk(0, 0, 0, 0,     0, 0, 0, BR,  1), o: mko(1, 0, 1, BR,  'h40,  0, 0, 0)};
        tbl[4] = '{i: mk(0, 0, 0, 0,     0, 0, 0, ALU, 1), o: mko(0, 0, 1, 0,   0,     0, 1, 0)};
        tbl[5] = '{i: mk(0, 0, 1, 'h80,  0, 1, 0, ALU, 1), o: mko(0, 0, 1, 0,   0,     0, 1, 0)};
        tbl[6] = '{i: mk(0, 0, 0, 0,     0, 0, 0, ALU, 1), o: mko(0, 0, 1, 0,   0,     0, 1, 0)};
        tbl[7] = '{i: mk(0, 0, 0, 0,     0, 0, 0, ALU, 1), o: mko(0, 1, 1, ALU, 'h80,  0, 1, 0)};
        tbl[8] = '{i: mk(0, 0, 0, 0,     0, 0, 0, ALU, 1), o: mko(0, 0, 1, 0,   0,     0, 1, 0)};

        for (int k = 0; k < 9; k++) begin
            apply(tbl[k].i);
            compare_out($sformatf("vec%0d", k), tbl[k].o);
        end

        // mispredicted branch 0x100 with 0x44 and 0x48 in flight, then held by a 4-cycle stall
        apply(mk(0, 0, 1, 'h100, 0, 0, 0, ALU, 0));
        apply(mk(0, 0, 1, 'h44,  1, 1, 1, ALU, 0));
        apply(mk(0, 0, 1, 'h48,  1, 1, 1, BR,  1));
        chk("squash.mp_set", {31'b0, a_mp}, 32'd1);
        chk("squash.pc", a_pc, 32'h100);
        for (int k = 0; k < 4; k++) begin
            apply(mk(0, 1, 1, 'h55, 1, 1, 1, ALU, 0));
            chk($sformatf("stall%0d.mp", k), {31'b0, a_mp}, 32'd1);
            chk($sformatf("stall%0d.pc", k), a_pc, 32'h100);
            chk($sformatf("stall%0d.brc", k), {28'b0, a_brc}, 32'd1);
            chk($sformatf("stall%0d.mpc", k), {28'b0, a_mpc}, 32'd0);
        end
        apply(mk(0, 0, 1, 'h200, 0, 0, 0, ALU, 0));
        chk("squash.mp_clr", {31'b0, a_mp}, 32'd0);
        chk("squash.opc", {25'b0, a_opc}, 32'd0);
        chk("squash.brc", {28'b0, a_brc}, 32'd2);
        chk("squash.mpc", {28'b0, a_mpc}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            apply(mk(0, 0, 1, 'h300 + 4 * k, 0, 0, 1, ALU, 0));
            chk($sformatf("noleak%0d.pc44", k), {31'b0, a_pc != 32'h44}, 32'd1);
            chk($sformatf("noleak%0d.pc48", k), {31'b0, a_pc != 32'h48}, 32'd1);
            chk($sformatf("noleak%0d.mp", k), {31'b0, a_mp}, 32'd0);
        end

        // reset while a mispredict is pending and the pipe is stalled
        apply(mk(0, 0, 1, 'h400, 0, 0, 1, ALU, 0));
        apply(mk(0, 0, 0, 0,     0, 0, 0, ALU, 0));
        apply(mk(0, 0, 0, 0,     0, 0, 0, BR,  0));
        chk("rstmid.mp_set", {31'b0, a_mp}, 32'd1);
        apply(mk(1, 1, 1, 'h500, 1, 1, 1, BR, 1));
        compare_out("rstmid", mko(0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("rstmid.mpc_after", b_mpc, 32'd0);

        // back-to-back mispredicted branches drive the 4-bit counters to saturation
        for (int k = 0; k < 120; k++)
            apply(mk(0, 0, 1, 'h1000 + 4 * k, 0, 0, 0, BR, 1));
        chk("sat.brc4", {28'b0, a_brc}, 32'hF);
        chk("sat.mpc4", {28'b0, a_mpc}, 32'hF);
        chk("sat.enough", {31'b0, b_mpc >= 32'd20}, 32'd1);

        // random traffic against the model
        for (int k = 0; k < 2000; k++) begin
            r.rst       = ($urandom_range(0, 99) == 0);
            r.stall     = ($urandom_range(0, 3) == 0);
            r.if_valid  = 1'($urandom_range(0, 1));
            r.if_pc     = $urandom;
            r.lc        = 1'($urandom_range(0, 1));
            r.gl        = 1'($urandom_range(0, 1));
            r.tn        = 1'($urandom_range(0, 1));
            r.ex_br_en  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0, 1:    r.ex_opcode = BR;
                2:       r.ex_opcode = ALU;
                default: r.ex_opcode = 7'($urandom);
            endcase
            apply(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
